// File: rtl/l1b_buyruk_yanitlayici_if.sv
`default_nettype none
// ============================================================================
// Module   : l1b_buyruk_yanitlayici_if
// Purpose  : Bundles the getir1 request port, the getir2 response port, the
//            instruction-memory request/reply port and the error flag of the
//            instruction-side responder into one interface.
// Ports    : slave  modport - seen from the responder (l1b_buyruk_yanitlayici)
//            master modport - seen from the surrounding fetch/memory logic
// Revision : 1.0 - initial release
// ============================================================================
interface l1b_buyruk_yanitlayici_if #(
  parameter int PS_BIT   = 32,
  parameter int VERI_BIT = 32
);
  // getir1 -> responder fetch requests
  logic [PS_BIT-1:0]   g1_istek_ps_i;
  logic                g1_istek_gecerli_i;
  logic                g1_istek_hazir_o;
  // responder -> getir2 instruction responses
  logic [VERI_BIT-1:0] l1b_buyruk_o;
  logic                l1b_buyruk_gecerli_o;
  logic                l1b_buyruk_hazir_i;
  // responder <-> instruction memory
  logic [PS_BIT-1:0]   bellek_istek_adres_o;
  logic                bellek_istek_gecerli_o;
  logic                bellek_istek_hazir_i;
  logic [VERI_BIT-1:0] bellek_yanit_veri_i;
  logic                bellek_yanit_gecerli_i;
  // sticky protocol error
  logic                hata_o;

  modport slave (
    input  g1_istek_ps_i, g1_istek_gecerli_i,
    output g1_istek_hazir_o,
    output l1b_buyruk_o, l1b_buyruk_gecerli_o,
    input  l1b_buyruk_hazir_i,
    output bellek_istek_adres_o, bellek_istek_gecerli_o,
    input  bellek_istek_hazir_i, bellek_yanit_veri_i, bellek_yanit_gecerli_i,
    output hata_o
  );

  modport master (
    output g1_istek_ps_i, g1_istek_gecerli_i,
    input  g1_istek_hazir_o,
    input  l1b_buyruk_o, l1b_buyruk_gecerli_o,
    output l1b_buyruk_hazir_i,
    input  bellek_istek_adres_o, bellek_istek_gecerli_o,
    output bellek_istek_hazir_i, bellek_yanit_veri_i, bellek_yanit_gecerli_i,
    input  hata_o
  );
endinterface
`default_nettype wire

// File: rtl/l1b_buyruk_yanitlayici.sv
`default_nettype none
// ============================================================================
// Module   : l1b_buyruk_yanitlayici
// Purpose  : Instruction-side responder for the getir1/getir2 fetch protocol.
//            Forwards credit-limited fetch requests to instruction memory,
//            buffers the in-order memory replies in a small FIFO and returns
//            exactly one instruction per accepted request to getir2.
// Ports    : clk_i  - clock, all state updates on the rising edge
//            rstn_i - synchronous active-low reset
//            bus    - l1b_buyruk_yanitlayici_if.slave (request, response,
//                     memory and error signals)
// Revision : 1.0 - initial release
// ============================================================================
module l1b_buyruk_yanitlayici #(
  parameter int PS_BIT        = 32,
  parameter int VERI_BIT      = 32,
  parameter int MAKS_BEKLEYEN = 3
) (
  input  wire logic                  clk_i,
  input  wire logic                  rstn_i,
  l1b_buyruk_yanitlayici_if.slave    bus
);

  localparam int CW = $clog2(MAKS_BEKLEYEN + 1);
  localparam int PW = (MAKS_BEKLEYEN > 1) ? $clog2(MAKS_BEKLEYEN) : 1;

  localparam logic [CW-1:0] C_SAYAC_BIR = CW'(1);
  localparam logic [PW-1:0] C_PTR_BIR   = PW'(1);
  localparam logic [PW-1:0] C_PTR_SON   = PW'(MAKS_BEKLEYEN - 1);
  localparam logic [CW:0]   C_MAKS      = (CW + 1)'(MAKS_BEKLEYEN);

  // Registered state
  logic [CW-1:0]       ucusta_q, ucusta_d;       // issued, reply not yet received
  logic [CW-1:0]       fifo_sayac_q, fifo_sayac_d;
  logic [PW-1:0]       yaz_ptr_q, yaz_ptr_d;
  logic [PW-1:0]       oku_ptr_q, oku_ptr_d;
  logic                hata_q, hata_d;
  logic [VERI_BIT-1:0] fifo_mem_q [MAKS_BEKLEYEN];

  // Combinational control
  logic [CW:0] bekleyen;
  logic        kredi;
  logic        kabul;
  logic        yaz;
  logic        oku;
  logic        basibos;
  logic        cikis_gecerli;

  // Credit uses registered counts only: a slot freed this cycle is not
  // offered to getir1 until the next cycle.
  assign bekleyen = {1'b0, ucusta_q} + {1'b0, fifo_sayac_q};
  assign kredi    = (bekleyen < C_MAKS);

  assign bus.bellek_istek_adres_o   = {bus.g1_istek_ps_i[PS_BIT-1:2], 2'b00};
  assign bus.bellek_istek_gecerli_o = bus.g1_istek_gecerli_i && kredi;
  assign bus.g1_istek_hazir_o       = kredi && bus.bellek_istek_hazir_i;

  assign kabul   = bus.g1_istek_gecerli_i && bus.g1_istek_hazir_o;
  // Memory cannot be backpressured, so a reply with nothing in flight is
  // simply dropped and flagged.
  assign yaz     = bus.bellek_yanit_gecerli_i && (ucusta_q != '0);
  assign basibos = bus.bellek_yanit_gecerli_i && (ucusta_q == '0);

  assign cikis_gecerli = (fifo_sayac_q != '0);
  assign oku           = cikis_gecerli && bus.l1b_buyruk_hazir_i;

  assign bus.l1b_buyruk_gecerli_o = cikis_gecerli;
  assign bus.l1b_buyruk_o         = cikis_gecerli ? fifo_mem_q[oku_ptr_q] : '0;
  assign bus.hata_o               = hata_q;

  // Next-state logic for counters, pointers and error flag
  always_comb begin
    ucusta_d     = ucusta_q;
    fifo_sayac_d = fifo_sayac_q;
    yaz_ptr_d    = yaz_ptr_q;
    oku_ptr_d    = oku_ptr_q;
    hata_d       = hata_q | basibos;

    if (kabul && !yaz) begin
      ucusta_d = ucusta_q + C_SAYAC_BIR;
    end else if (!kabul && yaz) begin
      ucusta_d = ucusta_q - C_SAYAC_BIR;
    end

    if (yaz && !oku) begin
      fifo_sayac_d = fifo_sayac_q + C_SAYAC_BIR;
    end else if (!yaz && oku) begin
      fifo_sayac_d = fifo_sayac_q - C_SAYAC_BIR;
    end

    // Pointers wrap modulo the FIFO depth, which need not be a power of two.
    if (yaz) begin
      yaz_ptr_d = (yaz_ptr_q == C_PTR_SON) ? '0 : yaz_ptr_q + C_PTR_BIR;
    end
    if (oku) begin
      oku_ptr_d = (oku_ptr_q == C_PTR_SON) ? '0 : oku_ptr_q + C_PTR_BIR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ucusta_q     <= '0;
      fifo_sayac_q <= '0;
      yaz_ptr_q    <= '0;
      oku_ptr_q    <= '0;
      hata_q       <= 1'b0;
    end else begin
      ucusta_q     <= ucusta_d;
      fifo_sayac_q <= fifo_sayac_d;
      yaz_ptr_q    <= yaz_ptr_d;
      oku_ptr_q    <= oku_ptr_d;
      hata_q       <= hata_d;
    end
  end

  // Data storage needs no reset: the output is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (rstn_i && yaz) begin
      fifo_mem_q[yaz_ptr_q] <= bus.bellek_yanit_veri_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l1b_buyruk_yanitlayici.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1b_buyruk_yanitlayici
// Purpose  : Directed self-checking bench for l1b_buyruk_yanitlayici.
//            Inputs change on the falling edge; outputs are sampled 1 time
//            unit later, well clear of the rising (active) edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1b_buyruk_yanitlayici;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  l1b_buyruk_yanitlayici_if #(.PS_BIT(32), .VERI_BIT(32)) bus ();

  l1b_buyruk_yanitlayici #(.PS_BIT(32), .VERI_BIT(32), .MAKS_BEKLEYEN(3)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  // Advance to the next falling edge (inputs are changed right after it).
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.g1_istek_ps_i          = '0;
    bus.g1_istek_gecerli_i     = 1'b0;
    bus.l1b_buyruk_hazir_i     = 1'b0;
    bus.bellek_istek_hazir_i   = 1'b1;
    bus.bellek_yanit_veri_i    = '0;
    bus.bellek_yanit_gecerli_i = 1'b0;
  endtask

  task automatic do_reset();
    cyc(); idle_inputs(); rstn = 1'b0;
    cyc(); cyc(); rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_gecerli: got %b want 0", bus.l1b_buyruk_gecerli_o); end
    checks++; if (bus.l1b_buyruk_o !== 32'h0) begin errors++; $display("FAIL reset_buyruk: got %h want 0", bus.l1b_buyruk_o); end
    checks++; if (bus.hata_o !== 1'b0) begin errors++; $display("FAIL reset_hata: got %b want 0", bus.hata_o); end
    checks++; if (bus.g1_istek_hazir_o !== 1'b1) begin errors++; $display("FAIL reset_hazir: got %b want 1", bus.g1_istek_hazir_o); end
    checks++; if (bus.bellek_istek_gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_bellek_gecerli: got %b want 0", bus.bellek_istek_gecerli_o); end
  endtask

  task automatic test_single_fetch();
    cyc(); bus.g1_istek_ps_i = 32'h0000_1003; bus.g1_istek_gecerli_i = 1'b1; bus.l1b_buyruk_hazir_i = 1'b1; #1;
    checks++; if (bus.bellek_istek_adres_o !== 32'h0000_1000) begin errors++; $display("FAIL single_adres: got %h want 00001000", bus.bellek_istek_adres_o); end
    checks++; if (bus.bellek_istek_gecerli_o !== 1'b1) begin errors++; $display("FAIL single_bellek_gecerli: got %b want 1", bus.bellek_istek_gecerli_o); end
    checks++; if (bus.g1_istek_hazir_o !== 1'b1) begin errors++; $display("FAIL single_hazir: got %b want 1", bus.g1_istek_hazir_o); end
    cyc(); bus.g1_istek_gecerli_i = 1'b0;
    cyc(); bus.bellek_yanit_veri_i = 32'h0000_0013; bus.bellek_yanit_gecerli_i = 1'b1; #1;
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bus.l1b_buyruk_gecerli_o); end
    cyc(); bus.bellek_yanit_gecerli_i = 1'b0; #1;
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b1) begin errors++; $display("FAIL single_gecerli: got %b want 1", bus.l1b_buyruk_gecerli_o); end
    checks++; if (bus.l1b_buyruk_o !== 32'h0000_0013) begin errors++; $display("FAIL single_buyruk: got %h want 00000013", bus.l1b_buyruk_o); end
    cyc(); #1;
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b0) begin errors++; $display("FAIL single_one_cycle: got %b want 0", bus.l1b_buyruk_gecerli_o); end
    checks++; if (bus.hata_o !== 1'b0) begin errors++; $display("FAIL single_hata: got %b want 0", bus.hata_o); end
    bus.l1b_buyruk_hazir_i = 1'b0;
  endtask

  task automatic test_credit_limit();
    logic [31:0] exp_data [4];
    logic        exp_hazir [4];
    exp_hazir = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_data  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 4; i++) begin
      cyc(); bus.g1_istek_ps_i = 32'h2000 + 32'(4 * i); bus.g1_istek_gecerli_i = 1'b1; #1;
      checks++; if (bus.g1_istek_hazir_o !== exp_hazir[i]) begin errors++; $display("FAIL credit_hazir[%0d]: got %b want %b", i, bus.g1_istek_hazir_o, exp_hazir[i]); end
    end
    checks++; if (bus.bellek_istek_gecerli_o !== 1'b0) begin errors++; $display("FAIL credit_bellek_gecerli: got %b want 0", bus.bellek_istek_gecerli_o); end
    // Reply to the first request; it is buffered, so the credit stays used.
    cyc(); bus.bellek_yanit_veri_i = exp_data[0]; bus.bellek_yanit_gecerli_i = 1'b1; #1;
    checks++; if (bus.g1_istek_hazir_o !== 1'b0) begin errors++; $display("FAIL credit_reply_hazir: got %b want 0", bus.g1_istek_hazir_o); end
    cyc(); bus.bellek_yanit_gecerli_i = 1'b0; bus.l1b_buyruk_hazir_i = 1'b1; #1;
    checks++; if (bus.g1_istek_hazir_o !== 1'b0) begin errors++; $display("FAIL credit_buffered_hazir: got %b want 0", bus.g1_istek_hazir_o); end
    checks++; if (bus.l1b_buyruk_o !== exp_data[0]) begin errors++; $display("FAIL credit_first_data: got %h want %h", bus.l1b_buyruk_o, exp_data[0]); end
    // After the pop the 4th request (still held) is accepted.
    cyc(); bus.l1b_buyruk_hazir_i = 1'b0; #1;
    checks++; if (bus.g1_istek_hazir_o !== 1'b1) begin errors++; $display("FAIL credit_after_pop_hazir: got %b want 1", bus.g1_istek_hazir_o); end
    checks++; if (bus.bellek_istek_adres_o !== 32'h0000_200C) begin errors++; $display("FAIL credit_4th_adres: got %h want 0000200c", bus.bellek_istek_adres_o); end
    // Drain: reply and pop overlap each cycle.
    cyc(); bus.g1_istek_gecerli_i = 1'b0; bus.bellek_yanit_veri_i = exp_data[1]; bus.bellek_yanit_gecerli_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cyc(); bus.l1b_buyruk_hazir_i = 1'b1;
      if (i < 3) bus.bellek_yanit_veri_i = exp_data[i + 1]; else bus.bellek_yanit_gecerli_i = 1'b0;
      #1;
      checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b1 || bus.l1b_buyruk_o !== exp_data[i]) begin errors++; $display("FAIL credit_drain[%0d]: got %b/%h want 1/%h", i, bus.l1b_buyruk_gecerli_o, bus.l1b_buyruk_o, exp_data[i]); end
    end
    cyc(); bus.l1b_buyruk_hazir_i = 1'b0; #1;
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b0) begin errors++; $display("FAIL credit_empty: got %b want 0", bus.l1b_buyruk_gecerli_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_data [3];
    exp_data = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.g1_istek_ps_i = 32'h3000 + 32'(4 * i); bus.g1_istek_gecerli_i = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.g1_istek_gecerli_i = 1'b0; bus.bellek_yanit_veri_i = exp_data[i]; bus.bellek_yanit_gecerli_i = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      cyc(); bus.bellek_yanit_gecerli_i = 1'b0; #1;
      checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b1 || bus.l1b_buyruk_o !== exp_data[0]) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", i, bus.l1b_buyruk_gecerli_o, bus.l1b_buyruk_o, exp_data[0]); end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.l1b_buyruk_hazir_i = 1'b1; #1;
      checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b1 || bus.l1b_buyruk_o !== exp_data[i]) begin errors++; $display("FAIL bp_order[%0d]: got %b/%h want 1/%h", i, bus.l1b_buyruk_gecerli_o, bus.l1b_buyruk_o, exp_data[i]); end
    end
    cyc(); bus.l1b_buyruk_hazir_i = 1'b0; #1;
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", bus.l1b_buyruk_gecerli_o); end
  endtask

  task automatic test_simultaneous();
    // Build bekleyen=2: one in flight, one buffered (D0).
    cyc(); bus.g1_istek_ps_i = 32'h4000; bus.g1_istek_gecerli_i = 1'b1;
    cyc(); bus.g1_istek_ps_i = 32'h4004;
    cyc(); bus.g1_istek_gecerli_i = 1'b0; bus.bellek_yanit_veri_i = 32'hD0; bus.bellek_yanit_gecerli_i = 1'b1;
    // Accept + reply (D1) + pop (D0) together.
    cyc(); bus.g1_istek_ps_i = 32'h4008; bus.g1_istek_gecerli_i = 1'b1; bus.bellek_yanit_veri_i = 32'hD1; bus.l1b_buyruk_hazir_i = 1'b1; #1;
    checks++; if (bus.g1_istek_hazir_o !== 1'b1) begin errors++; $display("FAIL sim_hazir: got %b want 1", bus.g1_istek_hazir_o); end
    checks++; if (bus.l1b_buyruk_o !== 32'hD0) begin errors++; $display("FAIL sim_pop_data: got %h want d0", bus.l1b_buyruk_o); end
    // bekleyen must now be exactly 2: one more accept, then credit runs out.
    cyc(); bus.g1_istek_ps_i = 32'h400C; bus.bellek_yanit_gecerli_i = 1'b0; bus.l1b_buyruk_hazir_i = 1'b0; #1;
    checks++; if (bus.g1_istek_hazir_o !== 1'b1) begin errors++; $display("FAIL sim_bekleyen2_hazir: got %b want 1", bus.g1_istek_hazir_o); end
    checks++; if (bus.l1b_buyruk_o !== 32'hD1) begin errors++; $display("FAIL sim_next_data: got %h want d1", bus.l1b_buyruk_o); end
    cyc(); bus.g1_istek_gecerli_i = 1'b0; bus.bellek_yanit_veri_i = 32'hD2; bus.bellek_yanit_gecerli_i = 1'b1; bus.l1b_buyruk_hazir_i = 1'b1; #1;
    checks++; if (bus.g1_istek_hazir_o !== 1'b0) begin errors++; $display("FAIL sim_full_hazir: got %b want 0", bus.g1_istek_hazir_o); end
    checks++; if (bus.l1b_buyruk_o !== 32'hD1) begin errors++; $display("FAIL sim_d1: got %h want d1", bus.l1b_buyruk_o); end
    cyc(); bus.bellek_yanit_veri_i = 32'hD3; #1;
    checks++; if (bus.l1b_buyruk_o !== 32'hD2) begin errors++; $display("FAIL sim_d2: got %h want d2", bus.l1b_buyruk_o); end
    cyc(); bus.bellek_yanit_gecerli_i = 1'b0; #1;
    checks++; if (bus.l1b_buyruk_o !== 32'hD3) begin errors++; $display("FAIL sim_d3: got %h want d3", bus.l1b_buyruk_o); end
    cyc(); bus.l1b_buyruk_hazir_i = 1'b0; #1;
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b0) begin errors++; $display("FAIL sim_empty: got %b want 0", bus.l1b_buyruk_gecerli_o); end
    checks++; if (bus.hata_o !== 1'b0) begin errors++; $display("FAIL sim_hata: got %b want 0", bus.hata_o); end
  endtask

  task automatic test_stray_reply();
    cyc(); bus.bellek_yanit_veri_i = 32'hEE; bus.bellek_yanit_gecerli_i = 1'b1; #1;
    checks++; if (bus.hata_o !== 1'b0) begin errors++; $display("FAIL stray_same_cycle: got %b want 0", bus.hata_o); end
    cyc(); bus.bellek_yanit_gecerli_i = 1'b0; #1;
    checks++; if (bus.hata_o !== 1'b1) begin errors++; $display("FAIL stray_hata: got %b want 1", bus.hata_o); end
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b0) begin errors++; $display("FAIL stray_no_output: got %b want 0", bus.l1b_buyruk_gecerli_o); end
    cyc(); cyc(); #1;
    checks++; if (bus.hata_o !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b want 1", bus.hata_o); end
  endtask

  task automatic test_reset_mid();
    // Leaves two in flight and one buffered, with hata still set.
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.g1_istek_ps_i = 32'h5000 + 32'(4 * i); bus.g1_istek_gecerli_i = 1'b1;
    end
    cyc(); bus.g1_istek_gecerli_i = 1'b0; bus.bellek_yanit_veri_i = 32'h55; bus.bellek_yanit_gecerli_i = 1'b1;
    cyc(); bus.bellek_yanit_gecerli_i = 1'b0; rstn = 1'b0;
    cyc(); rstn = 1'b1; bus.bellek_istek_hazir_i = 1'b0; #1;
    checks++; if (bus.l1b_buyruk_gecerli_o !== 1'b0) begin errors++; $display("FAIL rmid_gecerli: got %b want 0", bus.l1b_buyruk_gecerli_o); end
    checks++; if (bus.hata_o !== 1'b0) begin errors++; $display("FAIL rmid_hata: got %b want 0", bus.hata_o); end
    checks++; if (bus.g1_istek_hazir_o !== 1'b0) begin errors++; $display("FAIL rmid_hazir_low: got %b want 0", bus.g1_istek_hazir_o); end
    bus.bellek_istek_hazir_i = 1'b1; #1;
    checks++; if (bus.g1_istek_hazir_o !== 1'b1) begin errors++; $display("FAIL rmid_hazir_high: got %b want 1", bus.g1_istek_hazir_o); end
    // bekleyen=0: three fresh accepts then the credit runs out.
    for (int i = 0; i < 4; i++) begin
      cyc(); bus.g1_istek_ps_i = 32'h6000 + 32'(4 * i); bus.g1_istek_gecerli_i = 1'b1; #1;
      checks++; if (bus.g1_istek_hazir_o !== (i < 3)) begin errors++; $display("FAIL rmid_credit[%0d]: got %b want %b", i, bus.g1_istek_hazir_o, (i < 3)); end
    end
    do_reset();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_credit_limit();
    test_backpressure();
    test_simultaneous();
    test_stray_reply();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
